// File: rtl/branch_resolve_unit.sv
// Branch resolution at the execute/fetch boundary: captures ALU flags with a condition,
// decides taken/not-taken, and drives the PC redirect, a timed flush, and branch statistics.
module branch_resolve_unit #(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       cond,
  input  logic [31:0]      target,
  input  logic             zero,
  input  logic             negative,
  input  logic             positive,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  output logic             flush,
  output logic             flag_err,
  output logic [CNT_W-1:0] branch_count,
  output logic [CNT_W-1:0] taken_count
);

  typedef enum logic [1:0] {
    IDLE,
    RESOLVE,
    FLUSH
  } state_t;

  state_t     state, state_next;
  logic [3:0] flush_cnt, flush_cnt_next;
  logic       taken_q, branch_q, err_q;
  logic       taken_now, accept;

  assign accept = in_valid && in_ready;

  always_comb begin
    taken_now = 1'b0;
    unique case (cond)
      3'b000: taken_now = 1'b0;
      3'b001: taken_now = zero;
      3'b010: taken_now = !zero;
      3'b011: taken_now = negative;
      3'b100: taken_now = positive;
      3'b101: taken_now = zero || negative;
      3'b110: taken_now = zero || positive;
      3'b111: taken_now = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      flush_cnt <= 4'd0;
    end else begin
      state     <= state_next;
      flush_cnt <= flush_cnt_next;
    end
  end

  // in_valid is used directly here; in_ready is fixed by the state branch we are in.
  always_comb begin
    state_next     = state;
    flush_cnt_next = flush_cnt;
    in_ready       = 1'b0;
    redirect_valid = 1'b0;
    flush          = 1'b0;
    flag_err       = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = RESOLVE;
      end
      RESOLVE: begin
        flag_err = err_q;
        if (taken_q) begin
          redirect_valid = 1'b1;
          flush          = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            state_next     = FLUSH;
            flush_cnt_next = 4'(FLUSH_CYCLES - 1);
          end else begin
            state_next = IDLE;
          end
        end else begin
          in_ready = 1'b1;
          if (!in_valid) state_next = IDLE;
        end
      end
      FLUSH: begin
        flush          = 1'b1;
        flush_cnt_next = flush_cnt - 4'd1;
        if (flush_cnt <= 4'd1) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // redirect_pc only loads for taken requests so it holds across not-taken ones.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      taken_q      <= 1'b0;
      branch_q     <= 1'b0;
      err_q        <= 1'b0;
      redirect_pc  <= 32'd0;
      branch_count <= '0;
      taken_count  <= '0;
    end else begin
      if (accept) begin
        taken_q  <= taken_now;
        branch_q <= (cond != 3'b000);
        err_q    <= !$onehot({zero, negative, positive});
        if (taken_now) redirect_pc <= target;
      end
      if (state == RESOLVE) begin
        if (branch_q && (branch_count != '1)) branch_count <= branch_count + 1'b1;
        if (taken_q && (taken_count != '1)) taken_count <= taken_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: directed scenarios plus random requests
// compared against a transaction-level model of the resolve/flush/statistics rules.
module tb_branch_resolve_unit;

  localparam int FLUSH_CYCLES = 2;
  localparam int CNT_W        = 4;
  localparam int CNT_MAX      = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       cond;
  logic [31:0]      target;
  logic             zero, negative, positive;
  logic             redirect_valid;
  logic [31:0]      redirect_pc;
  logic             flush;
  logic             flag_err;
  logic [CNT_W-1:0] branch_count;
  logic [CNT_W-1:0] taken_count;

  int          checks = 0;
  int          errors = 0;
  int          model_branches = 0;
  int          model_taken = 0;
  logic [31:0] model_pc = 32'd0;

  branch_resolve_unit #(
    .FLUSH_CYCLES(FLUSH_CYCLES),
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .cond(cond),
    .target(target),
    .zero(zero),
    .negative(negative),
    .positive(positive),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .flush(flush),
    .flag_err(flag_err),
    .branch_count(branch_count),
    .taken_count(taken_count)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic ref_taken(input logic [2:0] c, input logic z, input logic n, input logic p);
    case (c)
      3'd0:    return 1'b0;
      3'd1:    return z;
      3'd2:    return !z;
      3'd3:    return n;
      3'd4:    return p;
      3'd5:    return z || n;
      3'd6:    return z || p;
      default: return 1'b1;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic doReset();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    step();
    step();
    rst_n          = 1'b1;
    model_branches = 0;
    model_taken    = 0;
    model_pc       = 32'd0;
  endtask

  // One request: wait for ready, present for a cycle, check the resolve cycle,
  // any flush tail, then the idle cycle with updated statistics.
  task automatic applyStimulus(input logic [2:0] c, input logic [31:0] t,
                               input logic z, input logic n, input logic p);
    int   waited = 0;
    logic exp_taken;
    logic exp_err;
    while (in_ready !== 1'b1 && waited < 20) begin
      step();
      waited++;
    end
    checkOutput("ready_before_req", {31'd0, in_ready}, 32'd1);
    cond = c; target = t; zero = z; negative = n; positive = p;
    in_valid = 1'b1;
    step();
    in_valid  = 1'b0;
    exp_taken = ref_taken(c, z, n, p);
    exp_err   = (int'(z) + int'(n) + int'(p)) != 1;
    if (exp_taken) model_pc = t;
    if (c != 3'd0 && model_branches < CNT_MAX) model_branches++;
    if (exp_taken && model_taken < CNT_MAX) model_taken++;
    checkOutput("resolve_redirect_valid", {31'd0, redirect_valid}, {31'd0, exp_taken});
    checkOutput("resolve_redirect_pc", redirect_pc, model_pc);
    checkOutput("resolve_flush", {31'd0, flush}, {31'd0, exp_taken});
    checkOutput("resolve_flag_err", {31'd0, flag_err}, {31'd0, exp_err});
    checkOutput("resolve_in_ready", {31'd0, in_ready}, {31'd0, !exp_taken});
    if (exp_taken) begin
      for (int k = 1; k < FLUSH_CYCLES; k++) begin
        step();
        checkOutput("flush_hold", {31'd0, flush}, 32'd1);
        checkOutput("flush_in_ready", {31'd0, in_ready}, 32'd0);
        checkOutput("flush_redirect_valid", {31'd0, redirect_valid}, 32'd0);
        checkOutput("flush_flag_err", {31'd0, flag_err}, 32'd0);
      end
    end
    step();
    checkOutput("idle_flush", {31'd0, flush}, 32'd0);
    checkOutput("idle_in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("idle_redirect_valid", {31'd0, redirect_valid}, 32'd0);
    checkOutput("idle_redirect_pc", redirect_pc, model_pc);
    checkOutput("branch_count", 32'(branch_count), 32'(model_branches));
    checkOutput("taken_count", 32'(taken_count), 32'(model_taken));
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; cond = 3'd0; target = 32'd0;
    zero = 1'b0; negative = 1'b0; positive = 1'b0;
    step();
    step();
    checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("rst_redirect_valid", {31'd0, redirect_valid}, 32'd0);
    checkOutput("rst_redirect_pc", redirect_pc, 32'd0);
    checkOutput("rst_flush", {31'd0, flush}, 32'd0);
    checkOutput("rst_flag_err", {31'd0, flag_err}, 32'd0);
    checkOutput("rst_branch_count", 32'(branch_count), 32'd0);
    checkOutput("rst_taken_count", 32'(taken_count), 32'd0);
    rst_n = 1'b1;

    $display("[TB] taken EQ branch");
    applyStimulus(3'd1, 32'h0000_0040, 1'b1, 1'b0, 1'b0);

    $display("[TB] back-to-back not-taken LT");
    doReset();
    for (int i = 0; i < 4; i++) begin
      cond = 3'd3; zero = 1'b0; negative = 1'b0; positive = 1'b1;
      target = 32'(i * 4 + 32'h80);
      in_valid = 1'b1;
      step();
      checkOutput("b2b_in_ready", {31'd0, in_ready}, 32'd1);
      checkOutput("b2b_redirect_valid", {31'd0, redirect_valid}, 32'd0);
      checkOutput("b2b_flush", {31'd0, flush}, 32'd0);
    end
    in_valid = 1'b0;
    step();
    model_branches = 4;
    checkOutput("b2b_branch_count", 32'(branch_count), 32'd4);
    checkOutput("b2b_taken_count", 32'(taken_count), 32'd0);
    checkOutput("b2b_redirect_pc", redirect_pc, 32'd0);

    $display("[TB] request held during flush");
    cond = 3'd7; target = 32'h100; zero = 1'b0; negative = 1'b0; positive = 1'b1;
    in_valid = 1'b1;
    step();
    checkOutput("hold_t1_redirect_valid", {31'd0, redirect_valid}, 32'd1);
    checkOutput("hold_t1_redirect_pc", redirect_pc, 32'h100);
    checkOutput("hold_t1_in_ready", {31'd0, in_ready}, 32'd0);
    cond = 3'd1; target = 32'h200; zero = 1'b1; negative = 1'b0; positive = 1'b0;
    step();
    checkOutput("hold_t2_in_ready", {31'd0, in_ready}, 32'd0);
    checkOutput("hold_t2_flush", {31'd0, flush}, 32'd1);
    checkOutput("hold_t2_redirect_valid", {31'd0, redirect_valid}, 32'd0);
    step();
    checkOutput("hold_t3_in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("hold_t3_redirect_valid", {31'd0, redirect_valid}, 32'd0);
    checkOutput("hold_t3_redirect_pc", redirect_pc, 32'h100);
    step();
    in_valid = 1'b0;
    checkOutput("hold_t4_redirect_valid", {31'd0, redirect_valid}, 32'd1);
    checkOutput("hold_t4_redirect_pc", redirect_pc, 32'h200);
    step();
    checkOutput("hold_t5_flush", {31'd0, flush}, 32'd1);
    step();
    model_branches = 6; model_taken = 2; model_pc = 32'h200;
    checkOutput("hold_branch_count", 32'(branch_count), 32'd6);
    checkOutput("hold_taken_count", 32'(taken_count), 32'd2);

    $display("[TB] non-one-hot flags on GE");
    applyStimulus(3'd6, 32'h300, 1'b1, 1'b0, 1'b1);

    $display("[TB] reset during flush");
    doReset();
    cond = 3'd7; target = 32'h400; zero = 1'b0; negative = 1'b1; positive = 1'b0;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    checkOutput("rstfl_redirect_valid", {31'd0, redirect_valid}, 32'd1);
    step();
    checkOutput("rstfl_flush_before", {31'd0, flush}, 32'd1);
    rst_n = 1'b0;
    step();
    checkOutput("rstfl_flush", {31'd0, flush}, 32'd0);
    checkOutput("rstfl_in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("rstfl_branch_count", 32'(branch_count), 32'd0);
    checkOutput("rstfl_taken_count", 32'(taken_count), 32'd0);
    checkOutput("rstfl_redirect_pc", redirect_pc, 32'd0);
    rst_n = 1'b1;
    model_branches = 0; model_taken = 0; model_pc = 32'd0;

    $display("[TB] saturation");
    for (int i = 0; i < 17; i++) applyStimulus(3'd7, 32'(i * 16), 1'b0, 1'b1, 1'b0);
    checkOutput("sat_taken_count", 32'(taken_count), 32'(CNT_MAX));

    $display("[TB] random requests");
    doReset();
    for (int i = 0; i < 40; i++) begin
      applyStimulus(3'($urandom_range(0, 7)), $urandom,
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Consumer end of the execute-stage ALU interface: latches the ALU flags (Zero, Negative, Positive) with a branch condition and target, resolves taken/not-taken, and drives the PC redirect and pipeline flush.
- Sits between the execute stage and fetch/decode.
- Uses a valid/ready handshake on input and a timed flush sequence.
- Keeps saturating branch/taken statistics counters.

Parameters:
- FLUSH_CYCLES, 2, number of cycles flush is asserted per taken branch (legal range 1..15).
- CNT_W, 16, width of the statistics counters.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous, active-low reset.
- in_valid  input  1  request present this cycle.
- in_ready  output  1  unit accepts a request this cycle.
- cond  input  3  branch condition code.
- target  input  32  branch target PC.
- zero  input  1  ALU Zero flag.
- negative  input  1  ALU Negative flag.
- positive  input  1  ALU Positive flag.
- redirect_valid  output  1  one-cycle pulse: load redirect_pc into PC.
- redirect_pc  output  32  registered target PC.
- flush  output  1  squash younger pipeline stages.
- flag_err  output  1  one-cycle pulse: flag inputs of an accepted request were not one-hot.
- branch_count  output  CNT_W  accepted requests with cond != 000, saturating.
- taken_count  output  CNT_W  taken branches, saturating.

Behaviour:
- Reset, sampled on the clk edge while rst_n=0:
  - State goes to IDLE.
  - All outputs go to 0 except in_ready, which goes to 1.
  - Counters clear.
  - An in-flight flush is abandoned.
- Condition decode (Z=zero, N=negative, P=positive):
  - 000 never
  - 001 EQ: Z
  - 010 NE: !Z
  - 011 LT: N
  - 100 GT: P
  - 101 LE: Z|N
  - 110 GE: Z|P
  - 111 always
- Accept: a request is accepted when in_valid && in_ready on a clk edge. cond, target and the flags are captured in that cycle (cycle T).
- States:
  - IDLE:
    - in_ready=1.
    - On accept, go to RESOLVE.
  - RESOLVE (cycle T+1, exactly one cycle):
    - If taken: redirect_valid=1, redirect_pc=captured target, flush=1.
    - If not taken: redirect_valid=0, flush=0.
    - in_ready=1 only when not taken, so back-to-back not-taken requests run at 1 per cycle.
    - Accept in RESOLVE: stay in RESOLVE with the new capture.
    - No accept and not taken: go to IDLE.
    - Taken and FLUSH_CYCLES>1: go to FLUSH with the flush counter loaded to FLUSH_CYCLES-1.
    - Taken and FLUSH_CYCLES=1: go to IDLE.
  - FLUSH:
    - flush=1, in_ready=0, redirect_valid=0.
    - Counter decrements each cycle; at 1, go to IDLE on the next edge.
    - Total flush assertion per taken branch is exactly FLUSH_CYCLES cycles, counting the RESOLVE cycle.
    - in_valid is ignored here (not accepted).
- redirect_pc holds its last value when redirect_valid=0.
- flag_err:
  - Asserted in the RESOLVE cycle when the captured {Z,N,P} is not one-hot.
  - Resolution still uses the decode table unchanged.
- Counters:
  - Updated in the RESOLVE cycle.
  - branch_count increments if cond != 000.
  - taken_count increments if taken.
  - Both saturate at all-ones and never wrap.
- cond=000 is a plain pass-through: it never redirects and is not counted.
- Reset wins over every other event in the same cycle, including mid-FLUSH (flush drops the next cycle) and accept.

Test Plan:
- Reset, then in_valid=1, cond=001, zero=1, target=0x0000_0040 -> at T+1: redirect_valid=1, redirect_pc=0x40, flush high for 2 cycles, in_ready low at T+2, high at T+3; taken_count=1, branch_count=1.
- cond=011 with negative=0, positive=1, on 4 consecutive cycles -> redirect_valid never asserts, in_ready stays 1, one accept per cycle, branch_count=4, taken_count=0.
- Taken cond=111, target=0x100, then in_valid held high with cond=001, zero=1, target=0x200 during FLUSH -> second request accepted only at T+3; redirect_pc=0x200 pulses at T+4.
- zero=1 and positive=1, cond=110 -> flag_err pulses 1 cycle, branch still taken.
- Taken branch, with rst_n=0 at T+2 -> flush=0, in_ready=1, counters 0 at T+3.
- Force taken_count to all-ones (CNT_W=4, 16 taken branches) -> count holds at 0xF, no wrap.
